// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS main control FSM with retired-instruction counter
// Optional DM_HANDSHAKE_EN: MRD/MWR wait for dm_ready before advancing.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             overflow,
    input  logic             dm_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             dm_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [1:0]       alu_ctr,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_EXR  = 4'd2;
    localparam logic [3:0] S_EXI  = 4'd3;
    localparam logic [3:0] S_MA   = 4'd4;
    localparam logic [3:0] S_MRD  = 4'd5;
    localparam logic [3:0] S_MWR  = 4'd6;
    localparam logic [3:0] S_WBA  = 4'd7;
    localparam logic [3:0] S_WBM  = 4'd8;
    localparam logic [3:0] S_BR   = 4'd9;
    localparam logic [3:0] S_HALT = 4'd10;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_r, is_addu, is_subu, is_slt, r_ok;
    logic is_ori, is_addi, is_lw, is_sw, is_beq, is_j;
    logic mem_done;

    logic [1:0] ex_src_b;
    logic       ex_ext;
    logic [1:0] ex_alu;

    assign is_r    = (opcode == OP_R);
    assign is_addu = is_r && (funct == FN_ADDU);
    assign is_subu = is_r && (funct == FN_SUBU);
    assign is_slt  = is_r && (funct == FN_SLT);
    assign r_ok    = is_addu || is_subu || is_slt;
    assign is_ori  = (opcode == OP_ORI);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J);

`ifdef DM_HANDSHAKE_EN
    assign mem_done = dm_ready;
`else
    logic dm_ready_unused;
    assign dm_ready_unused = dm_ready;
    assign mem_done        = 1'b1;
`endif

    // WBA repeats the EX-stage ALU setup so zero/overflow still describe this instruction.
    always_comb begin
        ex_src_b = is_r ? 2'b00 : 2'b10;
        ex_ext   = is_addi;
        if (is_r) begin
            ex_alu = is_addu ? 2'b00 : 2'b01;
        end else begin
            ex_alu = is_ori ? 2'b10 : 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (is_j)                  state_d = S_IF;
                else if (is_r)             state_d = r_ok ? S_EXR : S_HALT;
                else if (is_ori || is_addi) state_d = S_EXI;
                else if (is_lw || is_sw)   state_d = S_MA;
                else if (is_beq)           state_d = S_BR;
                else                       state_d = S_HALT;
            end
            S_EXR:  state_d = S_WBA;
            S_EXI:  state_d = S_WBA;
            S_MA:   state_d = is_lw ? S_MRD : S_MWR;
            S_MRD:  state_d = mem_done ? S_WBM : S_MRD;
            S_MWR:  state_d = mem_done ? S_IF : S_MWR;
            S_WBA:  state_d = S_IF;
            S_WBM:  state_d = S_IF;
            S_BR:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Every arrival in IF retires one instruction; HALT entry never does.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_IF) && (state_q != S_IF)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        ir_we      = 1'b0;
        dm_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_ctr    = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_IF: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = 2'b01;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                if (is_j) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                end
            end
            S_EXR, S_EXI: begin
                alu_src_a = 1'b1;
                alu_src_b = ex_src_b;
                ext_op    = ex_ext;
                alu_ctr   = ex_alu;
            end
            S_MA: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            S_MWR: dm_we = 1'b1;
            S_WBA: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ex_src_b;
                ext_op     = ex_ext;
                alu_ctr    = ex_alu;
                reg_we     = !(is_addi && overflow);
                reg_dst    = is_r ? 2'b01 : 2'b00;
                mem_to_reg = is_slt ? 2'b10 : 2'b00;
            end
            S_WBM: begin
                reg_we     = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_ctr   = 2'b01;
                pc_we     = zero;
                pc_src    = 2'b01;
            end
            S_HALT: illegal = 1'b1;
            default: ;
        endcase
        // Enables are gated directly by rst_n so nothing writes while reset is held.
        if (!rst_n) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            dm_we   = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state_o       = state_q;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm with instruction-level reference model
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          overflow = 1'b0;
    logic          dm_ready = 1'b0;
    logic          pc_we, ir_we, dm_we, reg_we, alu_src_a, ext_op, illegal;
    logic [1:0]    pc_src, reg_dst, mem_to_reg, alu_src_b, alu_ctr;
    logic [3:0]    state_o;
    logic [CW-1:0] instr_retired;

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .dm_ready(dm_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .dm_we(dm_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .alu_ctr(alu_ctr), .illegal(illegal), .state_o(state_o),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

`ifdef DM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    typedef struct {
        logic [20:0] v;
        int          ret;
        int          ph;
    } row_t;

    row_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   pushed = 0;
    int   popped = 0;
    int   cnt = 0;

    // Expected outputs for one cycle, taken straight from the state/instruction table.
    function automatic logic [20:0] exp_row(int ph, logic [5:0] op, logic [5:0] fn,
                                            logic z, logic ov, logic in_rst);
        logic       pcwe = 0, irwe = 0, dmwe = 0, regwe = 0, a = 0, ext = 0, ill = 0;
        logic [1:0] pcsrc = 0, rdst = 0, m2r = 0, b = 0, alu = 0;
        logic [3:0] st;
        logic       r, addi, ori, slt;
        logic [1:0] exalu;
        st    = 4'(ph);
        r     = (op == 6'd0);
        addi  = (op == 6'd8);
        ori   = (op == 6'd13);
        slt   = r && (fn == 6'd42);
        exalu = r ? ((fn == 6'd33) ? 2'd0 : 2'd1) : (ori ? 2'd2 : 2'd3);
        case (ph)
            0: begin irwe = 1; pcwe = 1; b = 2'd1; end
            1: begin b = 2'd3; ext = 1; if (op == 6'd2) begin pcwe = 1; pcsrc = 2'd2; end end
            2, 3: begin a = 1; b = r ? 2'd0 : 2'd2; ext = addi; alu = exalu; end
            4: begin a = 1; b = 2'd2; ext = 1; end
            6: dmwe = 1;
            7: begin
                a = 1; b = r ? 2'd0 : 2'd2; ext = addi; alu = exalu;
                regwe = !(addi && ov); rdst = r ? 2'd1 : 2'd0; m2r = slt ? 2'd2 : 2'd0;
            end
            8: begin regwe = 1; m2r = 2'd1; end
            9: begin a = 1; alu = 2'd1; pcwe = z; pcsrc = 2'd1; end
            10: ill = 1;
            default: ;
        endcase
        if (in_rst) begin pcwe = 0; irwe = 0; dmwe = 0; regwe = 0; ill = 0; end
        return {st, pcwe, pcsrc, irwe, dmwe, regwe, rdst, m2r, a, b, ext, alu, ill};
    endfunction

    task automatic cyc(int ph, logic [5:0] op, logic [5:0] fn, logic z, logic ov,
                       logic rdy, logic rstv);
        row_t r;
        @(posedge clk);
        #1;
        rst_n = rstv; opcode = op; funct = fn; zero = z; overflow = ov; dm_ready = rdy;
        r.v   = exp_row(ph, op, fn, z, ov, !rstv);
        r.ret = cnt % (1 << CW);
        r.ph  = ph;
        q.push_back(r);
        pushed++;
    endtask

    task automatic do_reset(int n);
        cnt = 0;
        for (int i = 0; i < n; i++)
            cyc(0, 6'(($urandom)), 6'(($urandom)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // Instruction-level model: expand one instruction into its state sequence.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, logic ov,
                             int waits, bit rst_mwr);
        int  phs[$];
        int  nmem, mk;
        bit  halted, cut;
        logic rdy;
        halted = 0; cut = 0; mk = 0;
        nmem = HS ? waits + 1 : 1;
        phs.push_back(0);
        phs.push_back(1);
        if (op == 6'd2) begin
        end else if (op == 6'd0) begin
            if (fn == 6'd33 || fn == 6'd35 || fn == 6'd42) begin phs.push_back(2); phs.push_back(7); end
            else halted = 1;
        end else if (op == 6'd13 || op == 6'd8) begin
            phs.push_back(3); phs.push_back(7);
        end else if (op == 6'd35) begin
            phs.push_back(4); for (int i = 0; i < nmem; i++) phs.push_back(5); phs.push_back(8);
        end else if (op == 6'd43) begin
            phs.push_back(4); for (int i = 0; i < nmem; i++) phs.push_back(6);
        end else if (op == 6'd4) begin
            phs.push_back(9);
        end else begin
            halted = 1;
        end
        if (halted) for (int i = 0; i < 20; i++) phs.push_back(10);
        foreach (phs[i]) begin
            if (cut) break;
            if (rst_mwr && phs[i] == 6) begin
                do_reset(1);
                cut = 1;
            end else begin
                if (phs[i] == 5 || phs[i] == 6) begin rdy = (mk >= waits); mk++; end
                else rdy = 1'($urandom);
                cyc(phs[i], op, fn, z, ov, rdy, 1'b1);
            end
        end
        if (cut) return;
        if (halted) do_reset(1);
        else cnt++;
    endtask

    initial begin
        row_t r;
        logic [20:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                popped++;
                got = {state_o, pc_we, pc_src, ir_we, dm_we, reg_we, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, ext_op, alu_ctr, illegal};
                checks++;
                if (got === r.v) passed++;
                else $display("FAIL outputs ph=%0d got=%h exp=%h (op=%b fn=%b z=%b ov=%b rdy=%b rst_n=%b)",
                              r.ph, got, r.v, opcode, funct, zero, overflow, dm_ready, rst_n);
                checks++;
                if (int'(instr_retired) == r.ret) passed++;
                else $display("FAIL instr_retired ph=%0d got=%0d exp=%0d", r.ph, instr_retired, r.ret);
            end
        end
    end

    initial begin
        int sel, w;
        logic [5:0] op, fn;
        do_reset(2);
        run_instr(6'd0, 6'd33, 1'b0, 1'b0, 0, 0);
        run_instr(6'd8, 6'd0, 1'b0, 1'b1, 0, 0);
        run_instr(6'd4, 6'd0, 1'b1, 1'b0, 0, 0);
        run_instr(6'd4, 6'd0, 1'b0, 1'b0, 0, 0);
        run_instr(6'd35, 6'd0, 1'b0, 1'b0, 3, 0);
        run_instr(6'd0, 6'd42, 1'b0, 1'b0, 0, 0);
        run_instr(6'd63, 6'd0, 1'b0, 1'b0, 0, 0);
        run_instr(6'd43, 6'd0, 1'b0, 1'b0, 0, 1);
        run_instr(6'd43, 6'd0, 1'b0, 1'b0, 2, 0);
        for (int i = 0; i < 18; i++) run_instr(6'd2, 6'($urandom), 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 10);
            w   = $urandom_range(0, 3);
            fn  = 6'($urandom);
            case (sel)
                0: begin op = 6'd0; fn = 6'd33; end
                1: begin op = 6'd0; fn = 6'd35; end
                2: begin op = 6'd0; fn = 6'd42; end
                3: begin
                    op = 6'd0;
                    while (fn == 6'd33 || fn == 6'd35 || fn == 6'd42) fn = 6'($urandom);
                end
                4: op = 6'd13;
                5: op = 6'd8;
                6: op = 6'd35;
                7: op = 6'd43;
                8: op = 6'd4;
                9: op = 6'd2;
                default: begin
                    op = 6'($urandom);
                    while (op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd8 ||
                           op == 6'd13 || op == 6'd35 || op == 6'd43) op = 6'($urandom);
                end
            endcase
            run_instr(op, fn, 1'($urandom), 1'($urandom), w, ($urandom_range(0, 15) == 0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (popped == pushed && q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got=%0d exp=%0d", popped, pushed);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
